// File: rtl/mem_lsu_queue.sv
// rtl/mem_lsu_queue.sv - in-order load/store queue issuing one op at a time to the dcache
module mem_lsu_queue #(
    parameter int NUM_LANES   = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int TAG_W       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_LANES-1:0]       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LANES-1:0]       in_we,
    input  logic [NUM_LANES*32-1:0]    in_addr,
    input  logic [NUM_LANES*2-1:0]     in_size,
    input  logic [NUM_LANES-1:0]       in_unsigned,
    input  logic [NUM_LANES*32-1:0]    in_wdata,
    input  logic [NUM_LANES*TAG_W-1:0] in_tag,
    output logic                       dc_req_valid,
    input  logic                       dc_req_ready,
    output logic                       dc_req_we,
    output logic [31:0]                dc_req_addr,
    output logic [3:0]                 dc_req_wstrb,
    output logic [31:0]                dc_req_wdata,
    input  logic                       dc_resp_valid,
    input  logic [31:0]                dc_resp_rdata,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [31:0]                res_data,
    output logic [TAG_W-1:0]           res_tag,
    output logic                       res_ale
);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t        state;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic             q_we    [QUEUE_DEPTH];
    logic [31:0]      q_addr  [QUEUE_DEPTH];
    logic [1:0]       q_size  [QUEUE_DEPTH];
    logic             q_uns   [QUEUE_DEPTH];
    logic [31:0]      q_wdata [QUEUE_DEPTH];
    logic [TAG_W-1:0] q_tag   [QUEUE_DEPTH];
    logic             q_ale   [QUEUE_DEPTH];

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        if (size == 2'd1)
            return a[0];
        else if (size[1])
            return a != 2'b00;
        else
            return 1'b0;
    endfunction

    // Free slots are judged before any pop in the same cycle.
    logic [CW-1:0] free_slots;
    logic          do_enq;
    logic [CW-1:0] n_valid;
    logic [PW-1:0] slot [NUM_LANES];

    assign free_slots = CW'(QUEUE_DEPTH) - count;
    assign in_ready   = (free_slots >= CW'(NUM_LANES)) && !flush;
    assign do_enq     = in_ready && (|in_valid);

    always_comb begin
        n_valid = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            slot[i] = tail + PW'(n_valid);
            n_valid = n_valid + CW'(in_valid[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (do_enq && in_valid[i]) begin
                q_we[slot[i]]    <= in_we[i];
                q_addr[slot[i]]  <= in_addr[32*i +: 32];
                q_size[slot[i]]  <= in_size[2*i +: 2];
                q_uns[slot[i]]   <= in_unsigned[i];
                q_wdata[slot[i]] <= in_wdata[32*i +: 32];
                q_tag[slot[i]]   <= in_tag[TAG_W*i +: TAG_W];
                q_ale[slot[i]]   <= misaligned(in_size[2*i +: 2], in_addr[32*i +: 2]);
            end
        end
    end

    logic             h_valid;
    logic             h_we;
    logic [31:0]      h_addr;
    logic [1:0]       h_size;
    logic             h_uns;
    logic [31:0]      h_wdata;
    logic [TAG_W-1:0] h_tag;
    logic             h_ale;

    assign h_valid = count != '0;
    assign h_we    = q_we[head];
    assign h_addr  = q_addr[head];
    assign h_size  = q_size[head];
    assign h_uns   = q_uns[head];
    assign h_wdata = q_wdata[head];
    assign h_tag   = q_tag[head];
    assign h_ale   = q_ale[head];

    logic [3:0]  strb;
    logic [31:0] wd_rep;
    logic [31:0] shifted;
    logic [31:0] load_val;

    always_comb begin
        strb     = 4'b1111;
        wd_rep   = h_wdata;
        shifted  = dc_resp_rdata >> {h_addr[1:0], 3'b000};
        load_val = shifted;
        case (h_size)
            2'd0: begin
                strb     = 4'b0001 << h_addr[1:0];
                wd_rep   = {4{h_wdata[7:0]}};
                load_val = {{24{shifted[7] & ~h_uns}}, shifted[7:0]};
            end
            2'd1: begin
                strb     = 4'b0011 << h_addr[1:0];
                wd_rep   = {2{h_wdata[15:0]}};
                load_val = {{16{shifted[15] & ~h_uns}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    // Request fields are forced to zero outside REQ so idle outputs stay clean.
    assign dc_req_valid = state == S_REQ;
    assign dc_req_we    = dc_req_valid && h_we;
    assign dc_req_addr  = dc_req_valid ? {h_addr[31:2], 2'b00} : 32'd0;
    assign dc_req_wstrb = dc_req_valid ? strb : 4'd0;
    assign dc_req_wdata = (dc_req_valid && h_we) ? wd_rep : 32'd0;

    logic pop;
    assign pop = (state == S_DONE) && res_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            res_ale   <= 1'b0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            // A request still owed a response must have that response swallowed.
            if (state == S_WAIT || state == S_DRAIN)
                state <= dc_resp_valid ? S_IDLE : S_DRAIN;
            else if (state == S_REQ && dc_req_ready)
                state <= S_DRAIN;
            else
                state <= S_IDLE;
        end else begin
            if (do_enq)
                tail <= tail + PW'(n_valid);
            if (pop)
                head <= head + PW'(1);
            count <= count + (do_enq ? n_valid : CW'(0)) - CW'(pop);
            case (state)
                S_IDLE: begin
                    if (h_valid) begin
                        if (h_ale) begin
                            state     <= S_DONE;
                            res_valid <= 1'b1;
                            res_data  <= '0;
                            res_tag   <= h_tag;
                            res_ale   <= 1'b1;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: if (dc_req_ready) state <= S_WAIT;
                S_WAIT: begin
                    if (dc_resp_valid) begin
                        state     <= S_DONE;
                        res_valid <= 1'b1;
                        res_data  <= h_we ? 32'd0 : load_val;
                        res_tag   <= h_tag;
                        res_ale   <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                    end
                end
                S_DRAIN: if (dc_resp_valid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu_queue.sv
// tb/tb_mem_lsu_queue.sv - directed bench with an in-order op-queue model for mem_lsu_queue
module tb_mem_lsu_queue;
    localparam int NL = 2;
    localparam int QD = 4;
    localparam int TW = 32;

    logic            clk = 1'b0;
    logic            reset, flush;
    logic [NL-1:0]   in_valid, in_we, in_unsigned;
    logic            in_ready;
    logic [NL*32-1:0] in_addr, in_wdata;
    logic [NL*2-1:0] in_size;
    logic [NL*TW-1:0] in_tag;
    logic            dc_req_valid, dc_req_ready, dc_req_we;
    logic [31:0]     dc_req_addr, dc_req_wdata;
    logic [3:0]      dc_req_wstrb;
    logic            dc_resp_valid = 1'b0;
    logic [31:0]     dc_resp_rdata = 32'd0;
    logic            res_valid, res_ready, res_ale;
    logic [31:0]     res_data;
    logic [TW-1:0]   res_tag;

    mem_lsu_queue #(.NUM_LANES(NL), .QUEUE_DEPTH(QD), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_addr(in_addr),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_wdata(in_wdata), .in_tag(in_tag),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_we(dc_req_we),
        .dc_req_addr(dc_req_addr), .dc_req_wstrb(dc_req_wstrb), .dc_req_wdata(dc_req_wdata),
        .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_ale(res_ale)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] tag;
    } op_t;

    int checks = 0;
    int errors = 0;

    op_t         mq[$];
    bit          resp_pend = 0, stale = 0, head_issued = 0, head_got = 0;
    logic [31:0] head_rdata = 32'd0;
    bit          resp_en;
    logic [31:0] resp_word;
    logic [31:0] res_d_log[$], res_t_log[$], req_a_log[$], req_d_log[$];
    logic        res_a_log[$];
    logic [3:0]  req_s_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic op_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata, input logic [31:0] tag);
        op_t o;
        o.we = we; o.addr = addr; o.size = size; o.uns = uns; o.wdata = wdata; o.tag = tag;
        return o;
    endfunction

    function automatic bit is_ale(input op_t o);
        return (o.size == 2'd1 && o.addr % 2 != 0) || (o.size >= 2'd2 && o.addr % 4 != 0);
    endfunction

    function automatic logic [31:0] exp_res(input op_t o, input logic [31:0] rd);
        int a;
        logic [31:0] w;
        if (is_ale(o) || o.we) return 32'd0;
        a = int'(o.addr % 4);
        w = rd >> (8 * a);
        if (o.size == 2'd0) begin
            w = w % 256;
            if (!o.uns && w >= 128) w = w + 32'hFFFFFF00;
        end else if (o.size == 2'd1) begin
            w = w % 65536;
            if (!o.uns && w >= 32768) w = w + 32'hFFFF0000;
        end
        return w;
    endfunction

    function automatic logic [3:0] exp_strb(input op_t o);
        int a;
        a = int'(o.addr % 4);
        if (o.size == 2'd0) return 4'(1 << a);
        if (o.size == 2'd1) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input op_t o);
        if (o.size == 2'd0) return (o.wdata % 256) * 32'h01010101;
        if (o.size == 2'd1) return (o.wdata % 65536) * 32'h00010001;
        return o.wdata;
    endfunction

    // Model update on the edge (pre-edge values), then dcache responder drive.
    always begin : model
        bit rdy;
        bit go;
        logic [31:0] wsamp;
        @(posedge clk);
        go = 0;
        wsamp = resp_word;
        if (reset) begin
            mq.delete();
            resp_pend = 0; stale = 0; head_issued = 0; head_got = 0;
        end else begin
            rdy = (QD - mq.size() >= NL) && !flush;
            if (dc_resp_valid) begin
                resp_pend = 0;
                if (stale) stale = 0;
                else begin head_rdata = dc_resp_rdata; head_got = 1; end
            end
            if (dc_req_valid && dc_req_ready) begin
                resp_pend = 1; head_issued = 1;
                req_a_log.push_back(dc_req_addr);
                req_s_log.push_back(dc_req_wstrb);
                req_d_log.push_back(dc_req_wdata);
            end
            if (flush) begin
                mq.delete();
                if (resp_pend) stale = 1;
                head_issued = 0; head_got = 0;
            end else begin
                if (res_valid && res_ready) begin
                    res_d_log.push_back(res_data);
                    res_t_log.push_back(res_tag);
                    res_a_log.push_back(res_ale);
                    if (mq.size() > 0) void'(mq.pop_front());
                    head_issued = 0; head_got = 0;
                end
                if (rdy) begin
                    for (int i = 0; i < NL; i++)
                        if (in_valid[i])
                            mq.push_back(mk(in_we[i], in_addr[32*i +: 32], in_size[2*i +: 2],
                                            in_unsigned[i], in_wdata[32*i +: 32], in_tag[TW*i +: TW]));
                end
            end
            go = resp_pend && resp_en;
        end
        #1;
        dc_resp_valid = go;
        dc_resp_rdata = go ? wsamp : 32'd0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", in_ready, 32'((QD - mq.size() >= NL) && !flush));
            if (dc_req_valid) begin
                chk("req_legal", 32'(mq.size() > 0 && !head_issued && !resp_pend && !is_ale(mq[0])), 1);
                if (mq.size() > 0) begin
                    chk("req_addr", dc_req_addr, mq[0].addr & 32'hFFFFFFFC);
                    chk("req_we", dc_req_we, 32'(mq[0].we));
                    if (mq[0].we) begin
                        chk("req_wstrb", dc_req_wstrb, exp_strb(mq[0]));
                        chk("req_wdata", dc_req_wdata, exp_wdata(mq[0]));
                    end
                end
            end
            if (res_valid) begin
                chk("res_nonempty", 32'(mq.size() > 0), 1);
                if (mq.size() > 0) begin
                    chk("res_tag", res_tag, mq[0].tag);
                    chk("res_ale", res_ale, 32'(is_ale(mq[0])));
                    if (!is_ale(mq[0]) && !mq[0].we)
                        chk("res_rdata_seen", 32'(head_got), 1);
                    chk("res_data", res_data, exp_res(mq[0], head_rdata));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input op_t o0, input bit v1, input op_t o1);
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk("push_ready", in_ready, 1);
        in_valid    = {v1, 1'b1};
        in_we       = {o1.we, o0.we};
        in_addr     = {o1.addr, o0.addr};
        in_size     = {o1.size, o0.size};
        in_unsigned = {o1.uns, o0.uns};
        in_wdata    = {o1.wdata, o0.wdata};
        in_tag      = {o1.tag, o0.tag};
        tick();
        in_valid = '0;
    endtask

    task automatic wait_res(input string nm);
        int n = 0;
        while (!res_valid && n < 20) begin tick(); n++; end
        chk(nm, res_valid, 1);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        res_ready = 1;
        while ((mq.size() != 0 || resp_pend) && n < 200) begin tick(); n++; end
        chk(nm, 32'(mq.size() == 0 && !resp_pend), 1);
    endtask

    task automatic clear_logs();
        res_d_log.delete(); res_t_log.delete(); res_a_log.delete();
        req_a_log.delete(); req_s_log.delete(); req_d_log.delete();
    endtask

    op_t nop;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        nop = mk(0, 0, 0, 0, 0, 0);
        reset = 1; flush = 0; in_valid = '0; in_we = '0; in_addr = '0; in_size = '0;
        in_unsigned = '0; in_wdata = '0; in_tag = '0;
        dc_req_ready = 1; res_ready = 1; resp_en = 1; resp_word = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_valid", dc_req_valid, 0);
        chk("rst_req_addr", dc_req_addr, 0);
        chk("rst_req_wstrb", dc_req_wstrb, 0);
        chk("rst_req_wdata", dc_req_wdata, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_res_ale", res_ale, 0);
        tick();
        reset = 0;

        // load word + store byte at offset 3
        resp_word = 32'h11223344;
        push(mk(0, 32'h100, 2, 0, 0, 32'h1000), 1, mk(1, 32'h203, 0, 0, 32'hAB, 32'h1004));
        drain("t1_drain");
        chk("t1_nres", res_d_log.size(), 2);
        chk("t1_load_data", res_d_log[0], 32'h11223344);
        chk("t1_load_tag", res_t_log[0], 32'h1000);
        chk("t1_store_data", res_d_log[1], 32'd0);
        chk("t1_store_tag", res_t_log[1], 32'h1004);
        chk("t1_st_addr", req_a_log[1], 32'h200);
        chk("t1_st_wstrb", req_s_log[1], 4'b1000);
        chk("t1_st_wdata", req_d_log[1], 32'hABABABAB);
        clear_logs();

        // signed and unsigned byte load from lane 1
        resp_word = 32'h000080FF;
        push(mk(0, 32'h101, 0, 0, 0, 32'h2000), 1, mk(0, 32'h101, 0, 1, 0, 32'h2004));
        drain("t2_drain");
        chk("t2_signed", res_d_log[0], 32'hFFFFFF80);
        chk("t2_unsigned", res_d_log[1], 32'h00000080);
        clear_logs();

        // misaligned half never reaches the dcache
        resp_word = 32'hCAFEF00D;
        push(mk(0, 32'h103, 1, 0, 0, 32'h3000), 1, mk(0, 32'h104, 2, 0, 0, 32'h3004));
        drain("t3_drain");
        chk("t3_ale_flag", res_a_log[0], 1);
        chk("t3_ale_data", res_d_log[0], 0);
        chk("t3_nreq", req_a_log.size(), 1);
        chk("t3_req_addr", req_a_log[0], 32'h104);
        chk("t3_word_data", res_d_log[1], 32'hCAFEF00D);
        clear_logs();

        // full queue backpressure
        resp_word = 32'h55AA55AA;
        res_ready = 0;
        push(mk(0, 32'h10, 2, 0, 0, 32'h4000), 1, mk(0, 32'h14, 2, 0, 0, 32'h4004));
        push(mk(0, 32'h18, 2, 0, 0, 32'h4008), 1, mk(0, 32'h1C, 2, 0, 0, 32'h400C));
        chk("t4_full", in_ready, 0);
        wait_res("t4_res1");
        chk("t4_still_full", in_ready, 0);
        res_ready = 1; tick(); res_ready = 0;
        chk("t4_one_free", in_ready, 0);
        wait_res("t4_res2");
        res_ready = 1; tick(); res_ready = 0;
        chk("t4_two_free", in_ready, 1);
        drain("t4_drain");
        clear_logs();

        // flush with a request outstanding
        resp_en = 0;
        tick();
        push(mk(0, 32'h20, 2, 0, 0, 32'h5000), 1, mk(0, 32'h24, 2, 0, 0, 32'h5004));
        push(mk(0, 32'h28, 2, 0, 0, 32'h5008), 0, nop);
        repeat (4) tick();
        flush = 1;
        #1;
        chk("t5_flush_ready", in_ready, 0);
        tick();
        flush = 0;
        resp_word = 32'hDEADBEEF;
        resp_en = 1;
        clear_logs();
        push(mk(0, 32'h30, 2, 0, 0, 32'h5010), 0, nop);
        drain("t5_drain");
        chk("t5_nres", res_d_log.size(), 1);
        chk("t5_tag", res_t_log[0], 32'h5010);
        chk("t5_nreq", req_a_log.size(), 1);
        chk("t5_req_addr", req_a_log[0], 32'h30);
        clear_logs();

        // async reset while a request is pending
        dc_req_ready = 0;
        push(mk(0, 32'h40, 2, 0, 0, 32'h6000), 0, nop);
        begin
            int n = 0;
            while (!dc_req_valid && n < 20) begin tick(); n++; end
        end
        chk("t6_in_req", dc_req_valid, 1);
        #2;
        reset = 1;
        #1;
        chk("t6_async_req_valid", dc_req_valid, 0);
        chk("t6_async_req_addr", dc_req_addr, 0);
        chk("t6_async_res_valid", res_valid, 0);
        tick();
        reset = 0;
        dc_req_ready = 1;
        chk("t6_ready_after", in_ready, 1);
        clear_logs();
        repeat (5) tick();
        chk("t6_no_req", req_a_log.size(), 0);
        chk("t6_no_res", res_d_log.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
